// File: rtl/silife_gen_scheduler.sv
// silife_gen_scheduler
//   Sequences Game-of-Life generations. Emits one-cycle step pulses to the
//   cell matrix enable in single-step, free-run (programmable period) or
//   burst-of-N modes. With display sync enabled, each step is held until the
//   MAX7219 scanner is idle and is followed by a one-cycle frame request.
//   Keeps a wrapping count of executed generations.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   i_run             level: free-run enable
//   i_step            pulse: one generation (accepted in IDLE only)
//   i_burst_start     pulse: burst of i_burst_count generations (IDLE only)
//   i_burst_count     burst length, sampled on accepted i_burst_start
//   i_abort           pulse: cancel activity, back to IDLE
//   i_period          idle cycles between steps, sampled at each reload
//   i_sync_display    level: hold step while display busy, then request frame
//   i_display_busy    MAX7219 scanner busy
//   i_clear_gen       pulse: zero the generation counter
//   o_step            one-cycle matrix enable
//   o_frame           one-cycle frame request
//   o_busy            high in every state except IDLE
//   o_burst_done      one-cycle pulse when the last burst step completes
//   o_generation      generations executed since reset/clear

module silife_gen_scheduler #(
    parameter int unsigned PERIOD_BITS = 24,
    parameter int unsigned BURST_BITS  = 16,
    parameter int unsigned GEN_BITS    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_run,
    input  logic                   i_step,
    input  logic                   i_burst_start,
    input  logic [BURST_BITS-1:0]  i_burst_count,
    input  logic                   i_abort,
    input  logic [PERIOD_BITS-1:0] i_period,
    input  logic                   i_sync_display,
    input  logic                   i_display_busy,
    input  logic                   i_clear_gen,
    output logic                   o_step,
    output logic                   o_frame,
    output logic                   o_busy,
    output logic                   o_burst_done,
    output logic [GEN_BITS-1:0]    o_generation
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SYNC,
        S_STEP,
        S_FRAME
    } state_t;

    typedef enum logic [1:0] {
        M_SINGLE,
        M_BURST,
        M_RUN
    } mode_t;

    state_t                 state_q, state_d;
    mode_t                  mode_q, mode_d;
    logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
    logic [BURST_BITS-1:0]  remaining_q, remaining_d;
    logic                   done_d;
    logic                   complete;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        complete    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_step) begin
                    mode_d  = M_SINGLE;
                    state_d = S_SYNC;
                end else if (i_burst_start) begin
                    // A zero-length burst is swallowed without any done pulse.
                    if (i_burst_count != '0) begin
                        remaining_d = i_burst_count;
                        mode_d      = M_BURST;
                        cnt_d       = i_period;
                        state_d     = S_WAIT;
                    end
                end else if (i_run) begin
                    mode_d  = M_RUN;
                    cnt_d   = i_period;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mode_q == M_RUN && !i_run) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_SYNC;
                end else begin
                    cnt_d = cnt_q - PERIOD_BITS'(1);
                end
            end
            S_SYNC: begin
                if (!(i_sync_display && i_display_busy)) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (mode_q == M_BURST) begin
                    remaining_d = remaining_q - BURST_BITS'(1);
                end
                if (i_sync_display) begin
                    state_d = S_FRAME;
                end else begin
                    complete = 1'b1;
                end
            end
            S_FRAME: complete = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // Shared by STEP (sync off) and FRAME; remaining_d already reflects
        // the decrement taken in STEP, so both paths test the same value.
        if (complete) begin
            case (mode_q)
                M_BURST: begin
                    if (remaining_d == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = i_period;
                        state_d = S_WAIT;
                    end
                end
                M_RUN: begin
                    if (!i_run) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = i_period;
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (i_abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    // Outputs are registered from the next-state decode so that they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mode_q       <= M_SINGLE;
            cnt_q        <= '0;
            remaining_q  <= '0;
            o_step       <= 1'b0;
            o_frame      <= 1'b0;
            o_busy       <= 1'b0;
            o_burst_done <= 1'b0;
            o_generation <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
            remaining_q  <= remaining_d;
            o_step       <= (state_d == S_STEP);
            o_frame      <= (state_d == S_FRAME);
            o_busy       <= (state_d != S_IDLE);
            o_burst_done <= done_d;
            if (i_clear_gen) begin
                o_generation <= '0;
            end else if (state_d == S_STEP) begin
                o_generation <= o_generation + GEN_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_silife_gen_scheduler.sv
// Testbench for silife_gen_scheduler. Expected pulse timing is derived from
// the scheduling rules: a step lands 2 cycles after an accepted single-step
// request, the first run/burst step lands period+3 cycles after acceptance,
// and later steps are spaced period+3 (sync off) or period+4 (sync on).
// A second instance with a 2-bit generation counter checks wrap-around.

module tb_silife_gen_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_run = 1'b0;
    logic        i_step = 1'b0;
    logic        i_burst_start = 1'b0;
    logic [15:0] i_burst_count = '0;
    logic        i_abort = 1'b0;
    logic [23:0] i_period = '0;
    logic        i_sync_display = 1'b0;
    logic        i_display_busy = 1'b0;
    logic        i_clear_gen = 1'b0;
    logic        o_step, o_frame, o_busy, o_burst_done;
    logic [31:0] o_generation;
    logic        w_step, w_frame, w_busy, w_burst_done;
    logic [1:0]  w_generation;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_gen = '0;

    always #5 clk = ~clk;

    silife_gen_scheduler #(.PERIOD_BITS(24), .BURST_BITS(16), .GEN_BITS(32)) dut (
        .clk(clk), .reset(reset), .i_run(i_run), .i_step(i_step),
        .i_burst_start(i_burst_start), .i_burst_count(i_burst_count),
        .i_abort(i_abort), .i_period(i_period), .i_sync_display(i_sync_display),
        .i_display_busy(i_display_busy), .i_clear_gen(i_clear_gen),
        .o_step(o_step), .o_frame(o_frame), .o_busy(o_busy),
        .o_burst_done(o_burst_done), .o_generation(o_generation)
    );

    silife_gen_scheduler #(.PERIOD_BITS(24), .BURST_BITS(16), .GEN_BITS(2)) dut_wrap (
        .clk(clk), .reset(reset), .i_run(i_run), .i_step(i_step),
        .i_burst_start(i_burst_start), .i_burst_count(i_burst_count),
        .i_abort(i_abort), .i_period(i_period), .i_sync_display(i_sync_display),
        .i_display_busy(i_display_busy), .i_clear_gen(i_clear_gen),
        .o_step(w_step), .o_frame(w_frame), .o_busy(w_busy),
        .o_burst_done(w_burst_done), .o_generation(w_generation)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // When a step is expected, the model counts it before comparing.
    task automatic check_all(input string tag, input bit es, input bit ef,
                             input bit eb, input bit ed);
        if (es) model_gen = model_gen + 32'd1;
        chk({tag, ".step"},  {63'd0, o_step},       {63'd0, es});
        chk({tag, ".frame"}, {63'd0, o_frame},      {63'd0, ef});
        chk({tag, ".busy"},  {63'd0, o_busy},       {63'd0, eb});
        chk({tag, ".done"},  {63'd0, o_burst_done}, {63'd0, ed});
        chk({tag, ".gen"},   {32'd0, o_generation}, {32'd0, model_gen});
        chk({tag, ".gen2"},  {62'd0, w_generation}, {62'd0, model_gen[1:0]});
    endtask

    function automatic bit has(input int q[$], input int v);
        foreach (q[i]) if (q[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    // kind 0: single step, kind 1: burst of n. Cycle c counts edges after acceptance.
    task automatic run_sched(input string tag, input int kind, input int n,
                             input int p, input bit s);
        int steps[$];
        int last;
        bit es, ef;
        if (kind == 0) steps.push_back(2);
        else for (int k = 0; k < n; k++) steps.push_back(p + 3 + k * (p + 3 + int'(s)));
        last = steps[steps.size() - 1];
        i_period = 24'(p);
        i_sync_display = s;
        i_display_busy = 1'b0;
        i_burst_count = 16'(n);
        if (kind == 0) i_step = 1'b1; else i_burst_start = 1'b1;
        for (int c = 1; c <= last + int'(s) + 2; c++) begin
            tick();
            i_step = 1'b0;
            i_burst_start = 1'b0;
            es = has(steps, c);
            ef = s && has(steps, c - 1);
            check_all(tag, es, ef, c <= last + int'(s),
                      (kind == 1) && (c == last + int'(s) + 1));
            // Without sync the scanner state must not matter.
            if (!s) i_display_busy = 1'($urandom_range(0, 1));
        end
        i_display_busy = 1'b0;
    endtask

    // Burst n=5, p=0, sync on: steps at 3, 7; frame at 4. Reset is held during
    // cycle rc-1 so cycle rc is the first that must read all zero.
    task automatic reset_mid(input string tag, input int rc);
        i_period = '0;
        i_sync_display = 1'b1;
        i_burst_count = 16'd5;
        i_burst_start = 1'b1;
        for (int c = 1; c <= rc + 2; c++) begin
            tick();
            i_burst_start = 1'b0;
            if (c < rc) begin
                check_all(tag, c == 3, c == 4, 1'b1, 1'b0);
            end else begin
                if (c == rc) model_gen = '0;
                check_all(tag, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            if (c == rc - 1) reset = 1'b1;
            if (c == rc) reset = 1'b0;
        end
        i_sync_display = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        check_all("reset_rel", 1'b0, 1'b0, 1'b0, 1'b0);

        // Single step, sync off, then sync on
        run_sched("single", 0, 1, 0, 1'b0);
        run_sched("single_sync", 0, 1, 3, 1'b1);

        // Burst of 3, period 5: steps 8 cycles apart
        run_sched("burst3", 1, 3, 5, 1'b0);

        // Free run, period 0, sync on, display busy for the first 10 cycles.
        // A step request mid-run must be ignored.
        i_period = '0;
        i_sync_display = 1'b1;
        i_display_busy = 1'b1;
        i_run = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            i_step = 1'b0;
            check_all("run_sync", c == 11 || c == 15, c == 12 || c == 16, c <= 16, 1'b0);
            if (c == 10) i_display_busy = 1'b0;
            if (c == 12) i_step = 1'b1;
            if (c == 16) i_run = 1'b0;
        end
        i_sync_display = 1'b0;

        // Abort during burst WAIT
        i_period = 24'd10;
        i_burst_count = 16'd100;
        i_burst_start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            i_burst_start = 1'b0;
            i_abort = 1'b0;
            check_all("abort", 1'b0, 1'b0, c <= 3, 1'b0);
            if (c == 3) i_abort = 1'b1;
        end

        // Zero-length burst is ignored
        i_burst_count = '0;
        i_burst_start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            i_burst_start = 1'b0;
            check_all("burst0", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Clear coincident with the step edge: clear wins
        i_period = '0;
        i_step = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            i_step = 1'b0;
            i_clear_gen = 1'b0;
            if (c == 2) model_gen = 32'hFFFF_FFFF; // incremented to 0 by check_all
            check_all("clear", c == 2, 1'b0, c <= 2, 1'b0);
            if (c == 1) i_clear_gen = 1'b1;
        end

        // Reset in STEP and in FRAME
        run_sched("pre_reset", 1, 2, 1, 1'b0);
        reset_mid("rst_step", 4);
        run_sched("pre_reset2", 0, 1, 0, 1'b0);
        reset_mid("rst_frame", 5);

        // Randomized schedules; also drives the 2-bit instance through wraps
        for (int it = 0; it < 14; it++) begin
            run_sched("rand", int'($urandom_range(0, 1)), int'($urandom_range(1, 4)),
                      int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
